// File: rtl/ntt_ctrl.sv
// ntt_ctrl: NTT/INVNTT/MULT sequencing controller with pipeline-aligned bank enables.
// Define NTT_CTRL_STAGE_STALL_EN to insert a pipeline-drain gap between NTT stages.
module ntt_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode_in,
    output logic [1:0] mode,
    output logic [7:0] clk_counter,
    output logic       rd_en,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);
    localparam int PIPE_LAT      = 6;
    localparam int STAGE_LEN     = 32;
    localparam int NUM_STAGES    = 7;
    localparam int MULT_LEN      = 140;
    localparam int MULT_WR_START = 12;
    localparam logic [1:0] MODE_MULT = 2'd2;

`ifdef NTT_CTRL_STAGE_STALL_EN
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif

    state_t              state;
    logic [2:0]          wait_cnt;
    logic [PIPE_LAT-1:0] rd_dly;
    logic [7:0]          last;

    assign last  = mode == MODE_MULT ? 8'(MULT_LEN - 1) : 8'(NUM_STAGES * STAGE_LEN - 1);
    assign rd_en = state == RUN;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    // MULT writes follow the counter directly; NTT writes trail reads by the pipeline depth
    assign wr_en = mode == MODE_MULT ? (state == RUN && clk_counter >= 8'(MULT_WR_START))
                                     : rd_dly[PIPE_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= 2'd0;
            clk_counter <= 8'd0;
            wait_cnt    <= 3'd0;
            rd_dly      <= '0;
        end else begin
            rd_dly <= {rd_dly[PIPE_LAT-2:0], rd_en};
            case (state)
                IDLE: if (start && mode_in != 2'd3) begin
                    mode        <= mode_in;
                    clk_counter <= 8'd0;
                    state       <= RUN;
                end
                RUN: if (clk_counter == last) begin
                    wait_cnt <= 3'd0;
                    state    <= DRAIN;
                end
`ifdef NTT_CTRL_STAGE_STALL_EN
                else if (mode != MODE_MULT && clk_counter[4:0] == 5'd31) begin
                    clk_counter <= clk_counter + 8'd1;
                    wait_cnt    <= 3'd0;
                    state       <= GAP;
                end
`endif
                else clk_counter <= clk_counter + 8'd1;
`ifdef NTT_CTRL_STAGE_STALL_EN
                GAP: if (wait_cnt == 3'(PIPE_LAT - 1)) state <= RUN;
                     else wait_cnt <= wait_cnt + 3'd1;
`endif
                DRAIN: if (wait_cnt == 3'(PIPE_LAT - 1)) state <= DONE;
                       else wait_cnt <= wait_cnt + 3'd1;
                DONE: begin
                    clk_counter <= 8'd0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: directed self-checking bench for ntt_ctrl.
module tb_ntt_ctrl;
    logic       clk = 0, rst = 1, start = 0;
    logic [1:0] mode_in = 0;
    logic [1:0] mode;
    logic [7:0] clk_counter;
    logic       rd_en, wr_en, busy, done;
    int checks = 0, errors = 0;

`ifdef NTT_CTRL_STAGE_STALL_EN
    localparam bit STALL = 1;
`else
    localparam bit STALL = 0;
`endif

    ntt_ctrl dut (.clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .mode(mode),
                  .clk_counter(clk_counter), .rd_en(rd_en), .wr_en(wr_en), .busy(busy), .done(done));

    always #5 clk = ~clk;

    // expected read enable and counter in cycle k after the accepting edge (k >= 1)
    function automatic void exp_at(input logic [1:0] m, input int k, output logic rd, output int cnt);
        int len, idx, run_total, s, off;
        bit gaps;
        len = (m == 2) ? 140 : 224;
        gaps = STALL && m != 2;
        run_total = len + (gaps ? 36 : 0);
        idx = k - 1;
        if (idx >= run_total) begin
            rd = 0; cnt = len - 1;
        end else if (gaps) begin
            s = idx / 38; off = idx % 38;
            rd = off < 32;
            cnt = off < 32 ? s * 32 + off : (s + 1) * 32;
        end else begin
            rd = 1; cnt = idx;
        end
    endfunction

    task automatic test_reset;
        checks++;
        if ({mode, clk_counter, rd_en, wr_en, busy, done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero", {mode, clk_counter, rd_en, wr_en, busy, done});
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || clk_counter !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b cnt=%0d, required 0/0", busy, clk_counter);
        end
    endtask

    task automatic test_op(input logic [1:0] m, input bit poke);
        int done_k, wr_total, bad_cnt, bad_rd, bad_wr, bad_ctl, first_bad, e_cnt;
        logic rd_hist [0:299];
        logic e_rd, e_wr;
        done_k = (m == 2) ? 147 : (STALL ? 267 : 231);
        wr_total = 0; bad_cnt = 0; bad_rd = 0; bad_wr = 0; bad_ctl = 0; first_bad = -1;
        @(negedge clk); start = 1; mode_in = m;
        @(posedge clk); #1; start = 0;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (poke && k == 20) begin start = 1; mode_in = 2'd1; end
            if (poke && k == 21) start = 0;
            exp_at(m, k, e_rd, e_cnt);
            rd_hist[k] = e_rd;
            e_wr = (m == 2) ? (e_rd && e_cnt >= 12) : (k > 6 && rd_hist[k-6]);
            if (k < done_k && clk_counter !== 8'(e_cnt)) begin bad_cnt++; if (first_bad < 0) first_bad = k; end
            if (k == done_k + 1 && clk_counter !== 8'd0) bad_cnt++;
            if (rd_en !== e_rd) bad_rd++;
            if (wr_en !== e_wr) bad_wr++;
            if (busy !== (k <= done_k) || done !== (k == done_k)) bad_ctl++;
            if (wr_en === 1'b1) wr_total++;
        end
        checks++;
        if (bad_cnt != 0) begin errors++; $display("FAIL cnt_seq mode %0d: %0d bad cycles (first k=%0d), required 0", m, bad_cnt, first_bad); end
        checks++;
        if (bad_rd != 0) begin errors++; $display("FAIL rd_seq mode %0d: %0d bad cycles, required 0", m, bad_rd); end
        checks++;
        if (bad_wr != 0) begin errors++; $display("FAIL wr_seq mode %0d: %0d bad cycles, required 0", m, bad_wr); end
        checks++;
        if (bad_ctl != 0) begin errors++; $display("FAIL busy_done mode %0d: %0d bad cycles, required 0 (done at E+%0d)", m, bad_ctl, done_k); end
        checks++;
        if (wr_total != ((m == 2) ? 128 : 224)) begin errors++; $display("FAIL wr_total mode %0d: got %0d, required %0d", m, wr_total, (m == 2) ? 128 : 224); end
        checks++;
        if (mode !== m) begin errors++; $display("FAIL mode_latched: got %0d, required %0d", mode, m); end
    endtask

    task automatic test_reserved(input logic [1:0] prev);
        @(negedge clk); start = 1; mode_in = 2'd3;
        @(negedge clk); start = 0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || mode !== prev) begin
            errors++;
            $display("FAIL reserved_mode: busy=%b rd=%b mode=%0d, required 0/0/%0d", busy, rd_en, mode, prev);
        end
    endtask

    task automatic test_abort;
        int n;
        bit seen_done;
        @(negedge clk); start = 1; mode_in = 2'd1;
        @(posedge clk); #1; start = 0;
        n = 0;
        while (clk_counter !== 8'd100 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL abort_reach100: timeout, cnt=%0d, required 100", clk_counter); end
        rst = 1; #1;
        checks++;
        if ({mode, clk_counter, rd_en, wr_en, busy, done} !== 14'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %b, required all zero", {mode, clk_counter, rd_en, wr_en, busy, done});
        end
        seen_done = 0;
        repeat (3) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) seen_done = 1; end
        @(negedge clk); rst = 0;
        repeat (10) begin @(posedge clk); #1; if (done !== 1'b0 || wr_en !== 1'b0) seen_done = 1; end
        checks++;
        if (seen_done) begin errors++; $display("FAIL abort_quiet: got activity after reset, required none"); end
    endtask

    initial begin
        #12;
        test_reset();
        test_op(2'd0, 0);
        test_op(2'd2, 1);
        test_reserved(2'd2);
        test_op(2'd1, 0);
        test_abort();
        test_op(2'd0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
